// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse train controller.
// Holds the controller state enumeration and the default widths used by
// pulse_train_ctrl and its period counter.
//   PW_DEFAULT : default width of the period configuration / period counter
//   CW_DEFAULT : default width of the pulse-count configuration / pulse index
//   state_t    : IDLE -> RUN -> FINISH -> IDLE
package pulse_ctrl_pkg;

  localparam int PW_DEFAULT = 16;
  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_period_counter.sv
// Spacing counter for the pulse train controller.
// Produces a single-cycle tick every 'period' enabled cycles. The tick is
// combinational and arrives one cycle ahead of the registered pulse that the
// controller derives from it.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   load   : capture 'period' and restart the spacing count
//   enable : count while high; tick is only produced while enabled
//   period : effective spacing in cycles (caller guarantees >= 1)
//   tick   : high in the cycle before the next pulse is due
module pulse_period_counter
  import pulse_ctrl_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] period_q;
  logic [PW-1:0] remain_q;

  // A remaining count of 1 means the next cycle is a pulse cycle. A period
  // of 1 loads 0, which also satisfies the tick condition, so every cycle
  // ticks in that case.
  assign tick = enable && (remain_q <= PW'(1));

  // The first interval is one shorter than the rest because the load cycle
  // itself counts as elapsed time; after each tick the full period is
  // reloaded so the next pulse lands exactly 'period' cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      remain_q <= '0;
    end else if (load) begin
      period_q <= period;
      remain_q <= period - PW'(1);
    end else if (enable) begin
      if (tick) begin
        remain_q <= period_q;
      end else begin
        remain_q <= remain_q - PW'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_train_ctrl.sv
// Pulse train controller.
// On an accepted start it emits a train of single-cycle pulses spaced by the
// configured period, either a fixed number of them or continuously until
// stopped, then strobes done for one cycle.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, dominates start/stop
//   start      : launch request, honoured only in IDLE with stop low
//   stop       : abort request, honoured only in RUN
//   cfg_period : pulse spacing in cycles (0 behaves as 1), latched on start
//   cfg_count  : pulses per train (0 = continuous), latched on start
//   busy       : train in progress (registered)
//   done       : single-cycle completion strobe (registered)
//   pulse      : single-cycle periodic pulse (registered)
//   pulse_idx  : zero-based pulse index while pulse=1, else 0
module pulse_train_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int PW = PW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [PW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_count,
  output logic          busy,
  output logic          done,
  output logic          pulse,
  output logic [CW-1:0] pulse_idx
);

  state_t        state, state_nxt;
  logic [CW-1:0] count_q, count_nxt;
  logic [CW-1:0] issued_q, issued_nxt;
  logic          last_q, last_nxt;
  logic          busy_nxt, done_nxt, pulse_nxt;
  logic [CW-1:0] idx_nxt;
  logic          accept;
  logic          tick;
  logic [PW-1:0] eff_period;

  assign eff_period = (cfg_period == '0) ? PW'(1) : cfg_period;

  pulse_period_counter #(
    .PW(PW)
  ) u_period (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .enable (state == ST_RUN),
    .period (eff_period),
    .tick   (tick)
  );

  // Next-state and next-output logic. Outputs are computed here and
  // registered below, so everything the outside world sees is a flop.
  // last_q marks that the pulse currently on the output is the final one of
  // a counted train; the cycle after it is always FINISH, which is also why
  // a stop landing on that same cycle produces only one done.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    issued_nxt = issued_q;
    last_nxt   = last_q;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    pulse_nxt  = 1'b0;
    idx_nxt    = '0;
    accept     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          accept     = 1'b1;
          state_nxt  = ST_RUN;
          busy_nxt   = 1'b1;
          count_nxt  = cfg_count;
          issued_nxt = '0;
          last_nxt   = 1'b0;
          // With a period of one the first pulse coincides with busy rising,
          // before the counter has had a chance to tick.
          if (eff_period == PW'(1)) begin
            pulse_nxt  = 1'b1;
            issued_nxt = CW'(1);
            last_nxt   = (cfg_count == CW'(1));
          end
        end
      end

      ST_RUN: begin
        if ((pulse && last_q) || stop) begin
          state_nxt = ST_FINISH;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (tick) begin
          pulse_nxt  = 1'b1;
          idx_nxt    = issued_q;
          issued_nxt = issued_q + CW'(1);
          last_nxt   = (count_q != '0) && (issued_q == count_q - CW'(1));
        end
      end

      ST_FINISH: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset clears everything, including any
  // train in flight, without producing a done strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count_q   <= '0;
      issued_q  <= '0;
      last_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse     <= 1'b0;
      pulse_idx <= '0;
    end else begin
      state     <= state_nxt;
      count_q   <= count_nxt;
      issued_q  <= issued_nxt;
      last_q    <= last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pulse     <= pulse_nxt;
      pulse_idx <= idx_nxt;
    end
  end

endmodule
